// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache. Combinational lookup in IDLE;
// misses stall fetch and refill the whole line from memory one beat at a time.
module instr_cache #(
    parameter int unsigned SETS  = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        flush,
    output logic [31:0] Instr,
    output logic        Stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned OFF_W = $clog2(WORDS);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;
    localparam int unsigned LO_W  = OFF_W + 2;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_REFILL = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [31:0]      r_data [SETS][WORDS];
    logic [OFF_W-1:0] r_beat;
    logic             r_drop;
    logic [31:0]      r_line_addr;

    logic [OFF_W-1:0] w_off;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0] w_tag;
    logic [TAG_W-1:0] w_fill_tag;
    logic             w_hit;
    logic             w_beat_we;
    logic             w_last_beat;
    logic             w_unused;

    assign w_off       = PC[LO_W-1:2];
    assign w_idx       = PC[LO_W+IDX_W-1:LO_W];
    assign w_tag       = PC[31:LO_W+IDX_W];
    assign w_fill_idx  = r_line_addr[LO_W+IDX_W-1:LO_W];
    assign w_fill_tag  = r_line_addr[31:LO_W+IDX_W];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_beat_we   = (r_state == S_REFILL) && mem_rvalid;
    assign w_last_beat = w_beat_we && (r_beat == OFF_W'(WORDS - 1));
    // Byte-offset bits of the fetch address carry no information.
    assign w_unused    = ^PC[1:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and outputs; everything is forced quiet while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        Instr       = '0;
        Stall       = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        Stall = 1'b1;
                    end else if (w_hit) begin
                        Instr = r_data[w_idx][w_off];
                    end else begin
                        Stall       = 1'b1;
                        w_state_nxt = S_REFILL;
                    end
                end
                S_REFILL: begin
                    Stall    = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = r_line_addr;
                    if (w_last_beat) w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Valid bits, refill address, beat counter and the flush-drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_beat      <= '0;
            r_drop      <= 1'b0;
            r_line_addr <= '0;
        end else if (r_state == S_IDLE) begin
            if (flush) begin
                r_valid <= '0;
            end else if (!w_hit) begin
                r_line_addr <= {w_tag, w_idx, LO_W'(0)};
                r_beat      <= '0;
            end
        end else begin
            if (flush) begin
                r_valid <= '0;
                r_drop  <= 1'b1;
            end
            if (w_beat_we) r_beat <= r_beat + OFF_W'(1);
            if (w_last_beat) begin
                r_drop <= 1'b0;
                if (!flush && !r_drop) r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays are not reset; validity alone guards them.
    always_ff @(posedge clk) begin
        if (!rst && w_beat_we) begin
            r_data[w_fill_idx][r_beat] <= mem_rdata;
            if (w_last_beat) r_tag[w_fill_idx] <= w_fill_tag;
        end
    end
endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: stimulus queues expected refill addresses
// and fetch results; a negedge monitor pops and compares them.
module tb_instr_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        flush;
    logic [31:0] Instr;
    logic        Stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] q_instr[$];
    logic [31:0] q_addr[$];
    logic        chk_en   = 1'b0;
    logic        prev_req = 1'b0;
    logic [31:0] cur_addr = '0;

    always #5 clk = ~clk;

    instr_cache #(.SETS(16), .WORDS(4)) dut (
        .clk(clk), .rst(rst), .PC(PC), .flush(flush),
        .Instr(Instr), .Stall(Stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: refill address on each new request, fetch result whenever Stall drops.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            if (mem_req && !prev_req) begin
                if (q_addr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_refill: mem_addr=%h, no refill expected", mem_addr);
                end else begin
                    e = q_addr.pop_front();
                    cur_addr <= e;
                    check("mem_addr_start", mem_addr, e);
                end
            end else if (mem_req) begin
                check("mem_addr_hold", mem_addr, cur_addr);
            end
            if (!Stall && chk_en && q_instr.size() != 0) begin
                e = q_instr.pop_front();
                check("instr", Instr, e);
            end
        end
        prev_req <= !rst && mem_req;
    end

    // Memory side of one refill: 2-cycle latency, then beats per pat (LSB first).
    task automatic serve(input logic [31:0] base, input logic [15:0] pat,
                         input int flush_k, input int chg_k, input logic [31:0] chg_pc);
        logic [31:0] pc_save;
        int beat;
        int k;
        pc_save = PC;
        beat    = 0;
        k       = 0;
        @(negedge clk); check("miss_stall", 32'(Stall), 32'd1);
        @(negedge clk); check("req_next", 32'(mem_req), 32'd1);
        repeat (2) @(posedge clk);
        while (beat < 4 && k < 32) begin
            #1;
            mem_rvalid = pat[k % 16];
            mem_rdata  = mem_rvalid ? base + 32'(beat) : 32'hBAD0_0000 + 32'(k);
            flush      = (k == flush_k);
            if (k == chg_k) PC = chg_pc;
            @(negedge clk);
            check("refill_stall", 32'(Stall), 32'd1);
            check("refill_req", 32'(mem_req), 32'd1);
            if (mem_rvalid) beat++;
            k++;
            @(posedge clk);
        end
        #1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        flush      = 1'b0;
        PC         = pc_save;
    endtask

    task automatic wait_instr();
        int i;
        i = 0;
        while (q_instr.size() != 0 && i < 64) begin
            @(posedge clk);
            i++;
        end
        #1;
        if (q_instr.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL instr_timeout: %0d responses outstanding, expected 0", q_instr.size());
            q_instr.delete();
        end else begin
            check("req_idle", 32'(mem_req), 32'd0);
        end
        chk_en = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] exp,
                         input bit miss, input logic [31:0] base);
        PC     = pc;
        chk_en = 1'b1;
        q_instr.push_back(exp);
        if (miss) begin
            q_addr.push_back({pc[31:4], 4'h0});
            serve(base, 16'hFFFF, -1, -1, 32'h0);
        end
        wait_instr();
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(negedge clk);
        check("flush_stall", 32'(Stall), 32'd1);
        check("flush_instr", Instr, 32'd0);
        check("flush_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_norefill", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; PC = 32'h40; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_instr", Instr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Cold miss then hit in the same line
        fetch(32'h40, 32'hA0, 1'b1, 32'hA0);
        fetch(32'h4C, 32'hA3, 1'b0, 32'h0);

        // Conflict eviction on index 4
        fetch(32'h140, 32'hB0, 1'b1, 32'hB0);
        fetch(32'h148, 32'hB2, 1'b0, 32'h0);
        fetch(32'h40,  32'hC0, 1'b1, 32'hC0);

        // Gapped beats 1,0,0,1,1,0,1
        PC = 32'h200; chk_en = 1'b1;
        q_instr.push_back(32'hD0); q_addr.push_back(32'h200);
        serve(32'hD0, 16'h0059, -1, -1, 32'h0);
        wait_instr();
        fetch(32'h204, 32'hD1, 1'b0, 32'h0);
        fetch(32'h208, 32'hD2, 1'b0, 32'h0);
        fetch(32'h20C, 32'hD3, 1'b0, 32'h0);

        // Flush in IDLE over a valid line
        PC = 32'h40;
        flush_pulse();
        fetch(32'h40, 32'hE0, 1'b1, 32'hE0);

        // Flush mid-refill: line dropped, same PC refills again
        PC = 32'h80; chk_en = 1'b1;
        q_instr.push_back(32'h100);
        q_addr.push_back(32'h80); q_addr.push_back(32'h80);
        serve(32'hF0,  16'hFFFF, 2, -1, 32'h0);
        serve(32'h100, 16'hFFFF, -1, -1, 32'h0);
        wait_instr();
        fetch(32'h200, 32'h110, 1'b1, 32'h110);

        // Reset after beat 1 of a refill
        PC = 32'h40;
        q_addr.push_back(32'h40);
        @(negedge clk); check("miss_stall", 32'(Stall), 32'd1);
        @(negedge clk); check("req_next", 32'(mem_req), 32'd1);
        repeat (2) @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            #1;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h5A0 + 32'(k);
            @(posedge clk);
        end
        #1;
        rst = 1'b1; mem_rdata = 32'hDEAD;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_mid_stall", 32'(Stall), 32'd0);
            check("rst_mid_req", 32'(mem_req), 32'd0);
            @(posedge clk);
        end
        #1;
        rst = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        fetch(32'h40, 32'h120, 1'b1, 32'h120);

        // PC moves to 0x80 during refill of 0x40
        flush_pulse();
        PC = 32'h40; chk_en = 1'b1;
        q_instr.push_back(32'h130); q_addr.push_back(32'h40);
        serve(32'h130, 16'hFFFF, -1, 1, 32'h80);
        wait_instr();
        fetch(32'h4C, 32'h133, 1'b0, 32'h0);

        repeat (4) @(posedge clk);
        if (q_addr.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL refill_missing: %0d expected refills never issued, expected 0", q_addr.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
